// File: rtl/regfile_sb.sv
// regfile_sb: GPR file with per-byte forwarding, writeback bypass and a post-reset zeroing sweep.
// Define REGFILE_SB_EN to build the pending-write scoreboard and pend_haz_o logic.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2,
    parameter int NFWD   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic                           ready_o,
    input  logic [NREAD-1:0]               re_i,
    input  logic [NREAD*ADDR_W-1:0]        raddr_i,
    output logic [NREAD*DATA_W-1:0]        rdata_o,
    input  logic [DATA_W/8-1:0]            we_i,
    input  logic [ADDR_W-1:0]              waddr_i,
    input  logic [DATA_W-1:0]              wdata_i,
    input  logic [NFWD*(DATA_W/8)-1:0]     fwd_we_i,
    input  logic [NFWD*ADDR_W-1:0]         fwd_addr_i,
    input  logic [NFWD*DATA_W-1:0]         fwd_data_i,
    output logic [NFWD-1:0]                fwd_haz_o,
    input  logic                           sb_set_i,
    input  logic [ADDR_W-1:0]              sb_addr_i,
    input  logic                           sb_clr_i,
    input  logic [ADDR_W-1:0]              sb_clr_addr_i,
    output logic [NREAD-1:0]               pend_haz_o
);
    localparam int NBYTE = DATA_W / 8;
    localparam int NREG  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_MAX = '1;

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              ready_q;
    logic              run;

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else if (state_q == S_INIT) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_MAX) begin
                state_q <= S_RUN;
                ready_q <= 1'b1;
            end
        end
    end

    assign run     = (state_q == S_RUN);
    assign ready_o = ready_q;

    logic [DATA_W-1:0] gpr_q [NREG];

    // NOTE: the array has no reset; the INIT sweep zeroes it one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (!run) begin
            gpr_q[cnt_q] <= '0;
        end else if (waddr_i != '0) begin
            for (int i = 0; i < NBYTE; i++) begin
                if (we_i[i]) gpr_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
        end
    end

    logic [ADDR_W-1:0] ra [NREAD];
    logic [NREAD-1:0]  valid;

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        assign ra[p]    = raddr_i[p*ADDR_W +: ADDR_W];
        assign valid[p] = run && re_i[p] && (ra[p] != '0);
    end

    logic [7:0] byte_sel;

    // NOTE: every combinational output gets a default before any branch so no path infers a latch.
    always_comb begin
        rdata_o   = '0;
        fwd_haz_o = '0;
        byte_sel  = '0;
        for (int p = 0; p < NREAD; p++) begin
            if (valid[p]) begin
                for (int i = 0; i < NBYTE; i++) begin
                    byte_sel = gpr_q[ra[p]][i*8 +: 8];
                    if (we_i[i] && waddr_i == ra[p]) byte_sel = wdata_i[i*8 +: 8];
                    // Walk oldest to youngest so the lowest-index stage overrides last.
                    for (int k = NFWD - 1; k >= 0; k--) begin
                        if (fwd_we_i[k*NBYTE + i] && fwd_addr_i[k*ADDR_W +: ADDR_W] == ra[p])
                            byte_sel = fwd_data_i[k*DATA_W + i*8 +: 8];
                    end
                    rdata_o[p*DATA_W + i*8 +: 8] = byte_sel;
                end
                for (int k = 0; k < NFWD; k++) begin
                    if (fwd_addr_i[k*ADDR_W +: ADDR_W] == ra[p] && fwd_we_i[k*NBYTE +: NBYTE] != '0)
                        fwd_haz_o[k] = 1'b1;
                end
            end
        end
    end

`ifdef REGFILE_SB_EN
    logic [NREG-1:0] pend_q, pend_d;

    // Clear is applied before set so a same-address collision leaves the register pending.
    always_comb begin
        pend_d = pend_q;
        if (!run) begin
            pend_d[cnt_q] = 1'b0;
        end else begin
            if (sb_clr_i) pend_d[sb_clr_addr_i] = 1'b0;
            if (sb_set_i && sb_addr_i != '0) pend_d[sb_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    // A retiring result masks its own hazard; its data arrives via forwarding or writeback.
    always_comb begin
        pend_haz_o = '0;
        for (int p = 0; p < NREAD; p++) begin
            pend_haz_o[p] = valid[p] && pend_q[ra[p]] && !(sb_clr_i && sb_clr_addr_i == ra[p]);
        end
    end
`else
    logic unused_sb;
    assign unused_sb  = ^{sb_set_i, sb_addr_i, sb_clr_i, sb_clr_addr_i};
    assign pend_haz_o = '0;
`endif

endmodule
